// File: rtl/ula_multiciclo_pkg.sv
// Shared definitions for the multi-cycle ALU: ALUCon codes, FSM states and
// a small op-classification helper used by the control logic.
package ula_multiciclo_pkg;

  localparam int ULA_WIDTH = 32;

  // ALUCon codes, shared with the ALU control stage
  localparam logic [2:0] ULA_ADD  = 3'b000;
  localparam logic [2:0] ULA_SUB  = 3'b001;
  localparam logic [2:0] ULA_MULT = 3'b010;
  localparam logic [2:0] ULA_DIV  = 3'b011;
  localparam logic [2:0] ULA_SLT  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } ula_state_e;

  function automatic logic is_long_op(input logic [2:0] alucon);
    return (alucon == ULA_MULT) || (alucon == ULA_DIV);
  endfunction

endpackage

// File: rtl/ula_iter_muldiv.sv
// Iterative signed mult/div engine: operates on magnitudes with a 2*WIDTH
// shift accumulator, one step per cycle, and applies the sign fix-up.
module ula_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step_s, prod_s;
  logic [WIDTH-1:0]   mag_q, mag_d, a_q, a_d;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, quo_s, rem_s;
  logic [WIDTH:0]     sum_s, rem_sh_s, diff_s;
  logic               div_q, div_d, a_neg_q, a_neg_d, b_neg_q, b_neg_d, dbz_q, dbz_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // One iteration of shift-add or restoring division, plus final fix-up
  always_comb begin
    mag_a_s  = a[WIDTH-1] ? ({WIDTH{1'b0}} - a) : a;
    mag_b_s  = b[WIDTH-1] ? ({WIDTH{1'b0}} - b) : b;
    sum_s    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
    rem_sh_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, mag_q};
    if (div_q) begin
      // partial remainder stays below the divisor, so its top bit is always clear
      if (!diff_s[WIDTH]) begin
        acc_step_s = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step_s = {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else if (acc_q[0]) begin
      acc_step_s = {sum_s, acc_q[WIDTH-1:1]};
    end else begin
      acc_step_s = {1'b0, acc_q[2*WIDTH-1:1]};
    end

    prod_s = (a_neg_q ^ b_neg_q) ? ({(2*WIDTH){1'b0}} - acc_step_s) : acc_step_s;
    quo_s  = acc_step_s[WIDTH-1:0];
    rem_s  = acc_step_s[2*WIDTH-1:WIDTH];
    if (dbz_q) begin
      lo = {WIDTH{1'b1}};
      hi = a_q;
    end else if (div_q) begin
      lo = (a_neg_q ^ b_neg_q) ? ({WIDTH{1'b0}} - quo_s) : quo_s;
      hi = a_neg_q ? ({WIDTH{1'b0}} - rem_s) : rem_s;
    end else begin
      lo = prod_s[WIDTH-1:0];
      hi = prod_s[2*WIDTH-1:WIDTH];
    end
    last = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state for operand capture and iteration
  always_comb begin
    acc_d   = acc_q;
    mag_d   = mag_q;
    a_d     = a_q;
    div_d   = div_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
    if (load) begin
      acc_d   = {{WIDTH{1'b0}}, (is_div ? mag_a_s : mag_b_s)};
      mag_d   = is_div ? mag_b_s : mag_a_s;
      a_d     = a;
      div_d   = is_div;
      a_neg_d = a[WIDTH-1];
      b_neg_d = b[WIDTH-1];
      dbz_d   = is_div && (b == {WIDTH{1'b0}});
      cnt_d   = {CW{1'b0}};
    end else if (step) begin
      acc_d = acc_step_s;
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      acc_d = acc_q;
    end
  end

  // Engine state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= {(2*WIDTH){1'b0}};
      mag_q   <= {WIDTH{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      div_q   <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dbz_q   <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      acc_q   <= acc_d;
      mag_q   <= mag_d;
      a_q     <= a_d;
      div_q   <= div_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU top: start/busy/done FSM, single-cycle add/sub/slt path,
// and registered result/hi/zero outputs fed by the iterative mult/div engine.
module ula_multiciclo
  import ula_multiciclo_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUCon,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  ula_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, single_s;
  logic [WIDTH-1:0] md_lo_s, md_hi_s;
  logic             zero_q, zero_d, busy_q, busy_d, done_q, done_d;
  logic             md_load_s, md_step_s, md_last_s;

  ula_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .load   (md_load_s),
    .step   (md_step_s),
    .is_div (ALUCon == ULA_DIV),
    .a      (A),
    .b      (B),
    .lo     (md_lo_s),
    .hi     (md_hi_s),
    .last   (md_last_s)
  );

  // Single-cycle datapath; reserved codes yield zero
  always_comb begin
    case (ALUCon)
      ULA_ADD: single_s = A + B;
      ULA_SUB: single_s = A - B;
      ULA_SLT: single_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: single_s = {WIDTH{1'b0}};
    endcase
  end

  // FSM next-state and output register updates
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    hi_d      = hi_q;
    zero_d    = zero_q;
    md_load_s = 1'b0;
    md_step_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (is_long_op(ALUCon)) begin
            md_load_s = 1'b1;
            state_d   = ST_CALC;
          end else begin
            result_d = single_s;
            zero_d   = (single_s == {WIDTH{1'b0}});
            state_d  = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        md_step_s = 1'b1;
        if (md_last_s) begin
          result_d = md_lo_s;
          hi_d     = md_hi_s;
          zero_d   = (md_lo_s == {WIDTH{1'b0}});
          state_d  = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CALC);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign hi     = hi_q;
  assign zero   = zero_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
